// File: rtl/npc_unit.sv
// Next-PC generator for the single-cycle MIPS core: selects among sequential, branch, jump,
// register-jump, interrupt and exception-return targets, and owns the EPC/EXL state.
module npc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic        j_en,
  input  logic [25:0] instr_index,
  input  logic        jr_en,
  input  logic [31:0] rs_val,
  input  logic        irq,
  input  logic        eret,
  output logic [31:0] npc,
  output logic [31:0] pc4,
  output logic [31:0] epc,
  output logic        exl
);

  // The reset vector belongs to the PC register; it is kept here for reference only.
  logic unused_reset_vec;
  assign unused_reset_vec = ^RESET_VEC;

  logic [31:0] epc_q, epc_d;
  logic        exl_q, exl_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        redir;
  logic [31:0] redir_tgt;
  logic        irq_acc;
  logic        eret_acc;

  assign pc4    = addr + 32'd4;
  assign br_tgt = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {pc4[31:28], instr_index, 2'b00};
  assign redir  = br_taken | j_en | jr_en;

  always_comb begin
    redir_tgt = br_tgt;
    if (jr_en) begin
      redir_tgt = rs_val;
    end else if (j_en) begin
      redir_tgt = j_tgt;
    end
  end

  assign irq_acc  = irq & ~exl_q & ~stall;
  assign eret_acc = eret & exl_q & ~stall;

  always_comb begin
    npc = pc4;
    if (irq_acc) begin
      npc = EXC_VEC;
    end else if (eret_acc) begin
      npc = epc_q;
    end else if (stall) begin
      npc = addr;
    end else if (redir) begin
      npc = redir_tgt;
    end else if (pend_valid_q) begin
      npc = pend_tgt_q;
    end
  end

  always_comb begin
    epc_d        = epc_q;
    exl_d        = exl_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    if (irq_acc) begin
      epc_d        = addr;
      exl_d        = 1'b1;
      pend_valid_d = 1'b0;
    end else if (eret_acc) begin
      exl_d        = 1'b0;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      // Latest redirect seen during a stall wins.
      if (redir) begin
        pend_valid_d = 1'b1;
        pend_tgt_d   = redir_tgt;
      end
    end else begin
      // Any unstalled cycle consumes (or supersedes) the held target.
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q        <= 32'd0;
      exl_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= 32'd0;
    end else begin
      epc_q        <= epc_d;
      exl_q        <= exl_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  assign epc = epc_q;
  assign exl = exl_q;

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit: the bench plays the PC register and checks npc/pc4/epc/exl
// against hand-computed values.
module tb_npc_unit;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        stall;
  logic        br_taken;
  logic [15:0] imm16;
  logic        j_en;
  logic [25:0] instr_index;
  logic        jr_en;
  logic [31:0] rs_val;
  logic        irq;
  logic        eret;
  logic [31:0] npc;
  logic [31:0] pc4;
  logic [31:0] epc;
  logic        exl;

  int n_checks = 0;
  int n_pass   = 0;

  npc_unit #(
    .RESET_VEC(32'h0000_3000),
    .EXC_VEC  (32'h0000_4180)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .stall      (stall),
    .br_taken   (br_taken),
    .imm16      (imm16),
    .j_en       (j_en),
    .instr_index(instr_index),
    .jr_en      (jr_en),
    .rs_val     (rs_val),
    .irq        (irq),
    .eret       (eret),
    .npc        (npc),
    .pc4        (pc4),
    .epc        (epc),
    .exl        (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic idle_ctrl();
    stall       = 1'b0;
    br_taken    = 1'b0;
    imm16       = 16'd0;
    j_en        = 1'b0;
    instr_index = 26'd0;
    jr_en       = 1'b0;
    rs_val      = 32'd0;
    irq         = 1'b0;
    eret        = 1'b0;
  endtask

  // Advance past the next rising edge, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_ctrl();
    rst  = 1'b1;
    addr = 32'h3000;
    tick();
    rst = 1'b0;
    #1;
    check("rst_exl", {31'd0, exl}, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_npc", npc, 32'h3004);
    check("rst_pc4", pc4, 32'h3004);

    // Sequential run
    for (int i = 0; i < 3; i++) begin
      addr = npc;
      tick();
      check("seq_npc", npc, 32'h3008 + 32'(i) * 32'd4);
    end

    // Branch backwards
    addr = 32'h3010; br_taken = 1'b1; imm16 = 16'hFFFC; #1;
    check("br_back", npc, 32'h3004);
    tick();
    idle_ctrl(); j_en = 1'b1; instr_index = 26'h0000C10; #1;
    check("jump", npc, 32'h3040);
    jr_en = 1'b1; rs_val = 32'h5000; #1;
    check("jr_over_j", npc, 32'h5000);
    tick();

    // Stall capture and release
    idle_ctrl(); addr = 32'h3020; stall = 1'b1; br_taken = 1'b1; imm16 = 16'd4; #1;
    check("stall_hold", npc, 32'h3020);
    tick();
    idle_ctrl(); stall = 1'b1; #1;
    check("stall_hold2", npc, 32'h3020);
    tick();
    stall = 1'b0; #1;
    check("pend_release", npc, 32'h3034);
    tick();
    addr = 32'h3034; #1;
    check("pend_cleared", npc, 32'h3038);
    tick();

    // Last redirect during a stall wins
    addr = 32'h3050; stall = 1'b1; br_taken = 1'b1; imm16 = 16'd8; #1;
    tick();
    br_taken = 1'b0; j_en = 1'b1; instr_index = 26'h0000D00; #1;
    tick();
    idle_ctrl(); #1;
    check("pend_last_wins", npc, 32'h3400);
    tick();

    // Live redirect beats pending, and pending still clears
    addr = 32'h3060; stall = 1'b1; br_taken = 1'b1; imm16 = 16'd2; #1;
    tick();
    idle_ctrl(); jr_en = 1'b1; rs_val = 32'h6000; #1;
    check("live_over_pend", npc, 32'h6000);
    tick();
    idle_ctrl(); addr = 32'h6000; #1;
    check("pend_dropped", npc, 32'h6004);
    tick();

    // Interrupt round trip
    addr = 32'h3040; irq = 1'b1; #1;
    check("irq_npc", npc, 32'h4180);
    tick();
    check("irq_epc", epc, 32'h3040);
    check("irq_exl", {31'd0, exl}, 32'd1);
    addr = 32'h4180; #1;
    check("irq_no_reentry", npc, 32'h4184);
    tick();
    check("irq_epc_held", epc, 32'h3040);
    addr = 32'h4184; eret = 1'b1; #1;
    check("eret_npc", npc, 32'h3040);
    tick();
    check("eret_exl", {31'd0, exl}, 32'd0);
    idle_ctrl();

    // Masking
    addr = 32'h3200; irq = 1'b1; stall = 1'b1; #1;
    check("irq_stall_npc", npc, 32'h3200);
    tick();
    check("irq_stall_exl", {31'd0, exl}, 32'd0);
    idle_ctrl(); addr = 32'h3100; eret = 1'b1; #1;
    check("eret_no_exl", npc, 32'h3104);
    tick();
    idle_ctrl();

    // Wrap
    addr = 32'hFFFF_FFFC; #1;
    check("wrap_pc4", pc4, 32'd0);
    check("wrap_npc", npc, 32'd0);
    tick();

    // Reset mid-op with exl=1 and a pending target
    addr = 32'h3300; irq = 1'b1; #1;
    tick();
    check("pre_rst_exl", {31'd0, exl}, 32'd1);
    idle_ctrl(); addr = 32'h4180; stall = 1'b1; br_taken = 1'b1; imm16 = 16'd4; #1;
    tick();
    idle_ctrl(); stall = 1'b1; rst = 1'b1; #1;
    tick();
    rst = 1'b0; stall = 1'b0; addr = 32'h3000; #1;
    check("midrst_exl", {31'd0, exl}, 32'd0);
    check("midrst_epc", epc, 32'd0);
    check("midrst_npc", npc, 32'h3004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
